// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, types and total-period helper
//
// Purpose: one place for the 640x480@60 default timing so the renderer and the
// sync controller derive line/frame periods identically.
// Ports: none (package).
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int RGB_W   = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Defaults: 100 MHz system clock divided down to a 25 MHz pixel clock.
    localparam int CLK_DIV_DEF   = 4;

    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    // Full period of one axis: visible + front porch + sync + back porch.
    function automatic int axis_total(input int display, input int front,
                                      input int sync_w, input int back);
        return display + front + sync_w + back;
    endfunction

    localparam int H_TOTAL_DEF = axis_total(H_DISPLAY_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int V_TOTAL_DEF = axis_total(V_DISPLAY_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/pixel_tick_gen.sv
// rtl/pixel_tick_gen.sv - system-clock divider producing a one-clk pixel strobe
//
// Purpose: counts 0..CLK_DIV-1 and raises p_tick while the count is at its top
// value, so p_tick is high for exactly one clk in every CLK_DIV. With CLK_DIV=1
// the counter never leaves 0 and p_tick stays high continuously.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset, clears the divider
//   p_tick - pixel strobe
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic p_tick
);

    // Keep at least one bit so CLK_DIV=1 still has a legal (constant) counter.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_count <= '0;
        end else if (div_count == DIV_MAX) begin
            div_count <= '0;
        end else begin
            div_count <= div_count + 1'b1;
        end
    end

    assign p_tick = (div_count == DIV_MAX);

endmodule

// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - VGA beam counters, sync generation and registered colour output
//
// Purpose: walks the beam across H_TOTAL x V_TOTAL pixel positions at the pixel
// rate, reports the current coordinate to the renderer and drives hsync/vsync
// and colour to the connector. Sync and colour are registered on the same tick
// from the same coordinate, so they leave the block one pixel after pixel_x/y.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   rgb_in      - renderer colour {R4,G4,B4} for the current coordinate
//   pixel_x/y   - current beam column/row (counter registers)
//   video_on    - current coordinate lies inside the visible area
//   p_tick      - one-clk pixel strobe
//   frame_start - one-clk pulse on the tick that wraps the frame
//   hsync/vsync - active-low sync, registered
//   vga_rgb     - registered colour to the DAC, blanked outside the visible area
module vga_sync_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        p_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] vga_rgb
);

    localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic   tick;
    coord_t h_count;
    coord_t v_count;
    logic   h_last;
    logic   v_last;
    logic   h_sync_zone;
    logic   v_sync_zone;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .p_tick (tick)
    );

    assign h_last      = (h_count == H_LAST);
    assign v_last      = (v_count == V_LAST);
    assign h_sync_zone = (h_count >= HS_START) && (h_count < HS_END);
    assign v_sync_zone = (v_count >= VS_START) && (v_count < VS_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
            vga_rgb <= 12'h000;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else if (tick) begin
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? '0 : v_count + coord_t'(1);
            end else begin
                h_count <= h_count + coord_t'(1);
            end
            // Registered from the pre-advance coordinate: one pixel of latency,
            // identical for colour and both syncs.
            vga_rgb <= video_on ? rgb_in : 12'h000;
            hsync   <= ~h_sync_zone;
            vsync   <= ~v_sync_zone;
        end
    end

    assign pixel_x  = h_count;
    assign pixel_y  = v_count;
    assign video_on = (h_count < H_VIS) && (v_count < V_VIS);
    assign p_tick   = tick;
    // Gated by rst so a tick coincident with reset never reports a frame wrap.
    assign frame_start = tick && !rst && h_last && v_last;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb/tb_vga_sync_ctrl.sv - directed self-checking bench for vga_sync_ctrl
module tb_vga_sync_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u4: default timing, CLK_DIV=4
    logic        rst4;
    logic [11:0] rgb4;
    logic [9:0]  x4, y4;
    logic        von4, pt4, fs4, hs4, vs4;
    logic [11:0] col4;

    // u1: CLK_DIV=1, default horizontal timing, short 10-line frame
    logic        rst1;
    logic [11:0] rgb1;
    logic [9:0]  x1, y1;
    logic        von1, pt1, fs1, hs1, vs1;
    logic [11:0] col1;

    int checks   = 0;
    int failures = 0;

    vga_sync_ctrl u4 (
        .clk(clk), .rst(rst4), .rgb_in(rgb4), .pixel_x(x4), .pixel_y(y4),
        .video_on(von4), .p_tick(pt4), .frame_start(fs4), .hsync(hs4),
        .vsync(vs4), .vga_rgb(col4)
    );

    vga_sync_ctrl #(
        .CLK_DIV(1), .V_DISPLAY(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u1 (
        .clk(clk), .rst(rst1), .rgb_in(rgb1), .pixel_x(x1), .pixel_y(y1),
        .video_on(von1), .p_tick(pt1), .frame_start(fs1), .hsync(hs1),
        .vsync(vs1), .vga_rgb(col1)
    );

    // Called at a negedge; returns at the negedge right after the next tick edge.
    task automatic tick4();
        int n;
        n = 0;
        while (pt4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (pt4 !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL tick4_timeout p_tick=%b exp=1 within 20 clks", pt4);
        end
        @(negedge clk);
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0;
    endtask

    task automatic test_reset();
        rst4 = 1'b1;
        rgb4 = 12'hFFF;
        repeat (3) @(negedge clk);
        checks++;
        if (x4 !== 10'd0 || y4 !== 10'd0) begin
            failures++; $display("FAIL reset_xy got x=%0d y=%0d exp x=0 y=0", x4, y4);
        end
        checks++;
        if (col4 !== 12'h000) begin
            failures++; $display("FAIL reset_rgb got=%h exp=000", col4);
        end
        checks++;
        if (hs4 !== 1'b1 || vs4 !== 1'b1) begin
            failures++; $display("FAIL reset_sync got hs=%b vs=%b exp 1 1", hs4, vs4);
        end
        checks++;
        if (pt4 !== 1'b0 || fs4 !== 1'b0 || von4 !== 1'b1) begin
            failures++; $display("FAIL reset_flags got pt=%b fs=%b von=%b exp 0 0 1", pt4, fs4, von4);
        end
        rst4 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (pt4 !== ((k % 4) == 3)) begin
                failures++; $display("FAIL ptick_cadence k=%0d got=%b exp=%b", k, pt4, (k % 4) == 3);
            end
            checks++;
            if (x4 !== 10'(k / 4) || y4 !== 10'd0) begin
                failures++; $display("FAIL first_ticks_x k=%0d got x=%0d y=%0d exp x=%0d y=0", k, x4, y4, k / 4);
            end
            if (k <= 3) begin
                checks++;
                if (col4 !== 12'h000 || hs4 !== 1'b1 || vs4 !== 1'b1) begin
                    failures++; $display("FAIL post_reset_out k=%0d got rgb=%h hs=%b vs=%b exp 000 1 1", k, col4, hs4, vs4);
                end
            end
            if (k == 4) begin
                checks++;
                if (col4 !== 12'hFFF) begin
                    failures++; $display("FAIL first_colour got=%h exp=fff", col4);
                end
            end
        end
    endtask

    task automatic test_line();
        int hs_low, first_low, last_low, xy_err, vs_err, von_err;
        logic [9:0] ex, ey;
        reset4();
        rgb4 = 12'h000;
        hs_low = 0; first_low = -1; last_low = -1; xy_err = 0; vs_err = 0; von_err = 0;
        for (int t = 1; t <= 800; t++) begin
            tick4();
            ex = 10'(t % 800);
            ey = 10'(t / 800);
            if (x4 !== ex || y4 !== ey) xy_err++;
            if (von4 !== (ex < 10'd640)) von_err++;
            if (vs4 !== 1'b1) vs_err++;
            if (hs4 === 1'b0) begin
                hs_low++;
                if (first_low < 0) first_low = int'(x4);
                last_low = int'(x4);
            end
        end
        checks++;
        if (xy_err != 0) begin
            failures++; $display("FAIL line_xy_track got errors=%0d exp=0", xy_err);
        end
        checks++;
        if (x4 !== 10'd0 || y4 !== 10'd1) begin
            failures++; $display("FAIL line_wrap got x=%0d y=%0d exp x=0 y=1", x4, y4);
        end
        checks++;
        if (hs_low != 96) begin
            failures++; $display("FAIL hsync_width got=%0d exp=96", hs_low);
        end
        checks++;
        if (first_low != 657 || last_low != 752) begin
            failures++; $display("FAIL hsync_window got first_x=%0d last_x=%0d exp 657 752", first_low, last_low);
        end
        checks++;
        if (vs_err != 0) begin
            failures++; $display("FAIL line_vsync_high got errors=%0d exp=0", vs_err);
        end
        checks++;
        if (von_err != 0) begin
            failures++; $display("FAIL line_video_on got errors=%0d exp=0", von_err);
        end
    endtask

    task automatic test_rgb();
        int err, n, stable_err;
        int hb, vb;
        logic [11:0] exp_c, prev;
        logic [9:0] xb;
        reset4();
        rgb4 = 12'hF0F;
        err = 0;
        for (int t = 1; t <= 801; t++) begin
            tick4();
            hb = (t - 1) % 800;
            vb = (t - 1) / 800;
            exp_c = (hb < 640 && vb < 480) ? 12'hF0F : 12'h000;
            if (col4 !== exp_c) err++;
            if (t == 1 || t == 641 || t == 800) begin
                checks++;
                if (col4 !== exp_c) begin
                    failures++; $display("FAIL rgb_point t=%0d got=%h exp=%h", t, col4, exp_c);
                end
            end
        end
        checks++;
        if (err != 0) begin
            failures++; $display("FAIL rgb_blanking got errors=%0d exp=0", err);
        end
        // Off-tick rgb_in changes must not reach vga_rgb; the tick value must, one pixel later.
        prev = col4;
        stable_err = 0;
        n = 0;
        while (pt4 !== 1'b1 && n < 20) begin
            rgb4 = 12'($urandom);
            @(negedge clk);
            if (col4 !== prev) stable_err++;
            n++;
        end
        checks++;
        if (stable_err != 0 || pt4 !== 1'b1) begin
            failures++; $display("FAIL rgb_hold got changes=%0d pt=%b exp 0 1", stable_err, pt4);
        end
        rgb4 = 12'h5A5;
        xb = x4;
        @(negedge clk);
        checks++;
        if (col4 !== 12'h5A5 || x4 !== xb + 10'd1) begin
            failures++; $display("FAIL rgb_lag got rgb=%h x=%0d exp rgb=5a5 x=%0d", col4, x4, xb + 10'd1);
        end
    endtask

    task automatic test_mid_reset(input int tx, input int ty);
        int n;
        reset4();
        rgb4 = 12'hF0F;
        n = 0;
        while (!(x4 == 10'(tx) && y4 == 10'(ty)) && n < 2000) begin
            tick4();
            n++;
        end
        checks++;
        if (x4 !== 10'(tx) || y4 !== 10'(ty)) begin
            failures++; $display("FAIL mid_reach got x=%0d y=%0d exp x=%0d y=%0d", x4, y4, tx, ty);
        end
        n = 0;
        while (pt4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        // Reset asserted on a tick cycle: reset must win over the advance.
        rst4 = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            checks++;
            if (x4 !== 10'd0 || y4 !== 10'd0 || col4 !== 12'h000 || hs4 !== 1'b1 || vs4 !== 1'b1) begin
                failures++;
                $display("FAIL mid_reset_state r=%0d got x=%0d y=%0d rgb=%h hs=%b vs=%b exp 0 0 000 1 1",
                         r, x4, y4, col4, hs4, vs4);
            end
        end
        rst4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (pt4 !== (k == 3)) begin
                failures++; $display("FAIL mid_resume_tick k=%0d got=%b exp=%b", k, pt4, k == 3);
            end
        end
        checks++;
        if (x4 !== 10'd1 || y4 !== 10'd0 || col4 !== 12'hF0F || hs4 !== 1'b1) begin
            failures++;
            $display("FAIL mid_resume_pos got x=%0d y=%0d rgb=%h hs=%b exp 1 0 f0f 1", x4, y4, col4, hs4);
        end
    endtask

    task automatic test_frame_clkdiv1();
        int tick_err, xy_err, rgb_err, fs_count, fs_first, fs_second;
        int vs_low, vs_first, vs_last, pos, hb, vb, st;
        logic [11:0] exp_c;
        logic [9:0] x_799, x_800, y_800;
        rgb1 = 12'hF0F;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (pt1 !== 1'b1 || col1 !== 12'h000 || fs1 !== 1'b0) begin
            failures++; $display("FAIL div1_reset got pt=%b rgb=%h fs=%b exp 1 000 0", pt1, col1, fs1);
        end
        rst1 = 1'b0;
        tick_err = 0; xy_err = 0; rgb_err = 0; fs_count = 0; fs_first = -1; fs_second = -1;
        vs_low = 0; vs_first = -1; vs_last = -1;
        x_799 = '0; x_800 = '0; y_800 = '0;
        for (int c = 1; c <= 16001; c++) begin
            @(negedge clk);
            if (pt1 !== 1'b1) tick_err++;
            st = c % 8000;
            if (x1 !== 10'(st % 800) || y1 !== 10'(st / 800)) xy_err++;
            pos = (c - 1) % 8000;
            hb = pos % 800;
            vb = pos / 800;
            exp_c = (hb < 640 && vb < 4) ? 12'hF0F : 12'h000;
            if (col1 !== exp_c) rgb_err++;
            if (fs1 === 1'b1) begin
                fs_count++;
                if (fs_first < 0) fs_first = c; else fs_second = c;
            end
            if (c <= 8000 && vs1 === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = c;
                vs_last = c;
            end
            if (c == 799) x_799 = x1;
            if (c == 800) begin x_800 = x1; y_800 = y1; end
        end
        checks++;
        if (tick_err != 0) begin
            failures++; $display("FAIL div1_ptick_high got low_cycles=%0d exp=0", tick_err);
        end
        checks++;
        if (x_799 !== 10'd799 || x_800 !== 10'd0 || y_800 !== 10'd1) begin
            failures++; $display("FAIL div1_line_period got x799=%0d x800=%0d y800=%0d exp 799 0 1", x_799, x_800, y_800);
        end
        checks++;
        if (xy_err != 0) begin
            failures++; $display("FAIL div1_xy_track got errors=%0d exp=0", xy_err);
        end
        checks++;
        if (fs_count != 2 || fs_first != 7999) begin
            failures++; $display("FAIL frame_start_pulses got count=%0d first=%0d exp 2 7999", fs_count, fs_first);
        end
        checks++;
        if (fs_second - fs_first != 8000) begin
            failures++; $display("FAIL frame_period got=%0d exp=8000", fs_second - fs_first);
        end
        checks++;
        if (vs_low != 1600) begin
            failures++; $display("FAIL vsync_width got=%0d exp=1600", vs_low);
        end
        checks++;
        if (vs_first != 4801 || vs_last != 6400) begin
            failures++; $display("FAIL vsync_window got first=%0d last=%0d exp 4801 6400", vs_first, vs_last);
        end
        checks++;
        if (rgb_err != 0) begin
            failures++; $display("FAIL div1_rgb_blanking got errors=%0d exp=0", rgb_err);
        end
    endtask

    initial begin
        rst4 = 1'b1;
        rst1 = 1'b1;
        rgb4 = 12'h000;
        rgb1 = 12'h000;
        test_reset();
        test_line();
        test_rgb();
        test_mid_reset(700, 0);
        test_mid_reset(300, 1);
        test_frame_clkdiv1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation exceeded 5 ms");
        $fatal(1);
    end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16.
REQ-002 SHALL have parameter H_DISPLAY, default 640, meaning visible pixels per line.
REQ-003 SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-004 SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixels.
REQ-005 SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-006 SHALL have parameter V_DISPLAY, default 480, meaning visible lines per frame.
REQ-007 SHALL have parameter V_FRONT, default 10, meaning vertical front porch in lines.
REQ-008 SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-009 SHALL have parameter V_BACK, default 33, meaning vertical back porch in lines.
REQ-010 SHALL have port clk, input, 1, meaning single system clock; all logic on its rising edge.
REQ-011 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-012 SHALL have port rgb_in, input, 12, meaning pixel colour from the renderer, {R4,G4,B4}.
REQ-013 SHALL have ports pixel_x and pixel_y, output, 10 each, meaning the current beam column and row.
REQ-014 SHALL have port video_on, output, 1, meaning the current (pixel_x, pixel_y) is visible.
REQ-015 SHALL have port p_tick, output, 1, meaning a one-clk pixel strobe.
REQ-016 SHALL have port frame_start, output, 1, meaning a one-clk pulse at frame wrap.
REQ-017 SHALL have ports hsync and vsync, output, 1 each, meaning active-low sync to the connector.
REQ-018 SHALL have port vga_rgb, output, 12, meaning registered colour to the DAC pins.

Function
REQ-019 SHALL use a divider counter 0..CLK_DIV-1 and assert p_tick for exactly one clk when the counter equals CLK_DIV-1; CLK_DIV=1 keeps p_tick high continuously.
REQ-020 SHALL advance h_count by 1 only on p_tick and wrap from H_TOTAL-1 to 0, with H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800).
REQ-021 SHALL advance v_count only on a p_tick where h_count wraps, wrapping from V_TOTAL-1 to 0, with V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525).
REQ-022 SHALL drive pixel_x = h_count and pixel_y = v_count directly from the counter registers, with no combinational path from rgb_in.
REQ-023 SHALL drive video_on combinationally as (h_count < H_DISPLAY) AND (v_count < V_DISPLAY).
REQ-024 SHALL, on each p_tick, register vga_rgb <= video_on ? rgb_in : 12'h000, giving exactly 1 pixel of latency from coordinates to colour.
REQ-025 SHALL register hsync on p_tick as low when H_DISPLAY+H_FRONT <= h_count < H_DISPLAY+H_FRONT+H_SYNC (656..751 by default), high otherwise, keeping it aligned with vga_rgb.
REQ-026 SHALL register vsync on p_tick as low when V_DISPLAY+V_FRONT <= v_count < V_DISPLAY+V_FRONT+V_SYNC (490..491 by default), high otherwise.
REQ-027 SHALL hold vga_rgb, hsync and vsync stable between p_ticks, ignoring rgb_in changes off-tick.
REQ-028 SHALL assert frame_start for one clk, coincident with the p_tick at which h_count = H_TOTAL-1 and v_count = V_TOTAL-1.

Reset
REQ-029 SHALL, when rst is sampled high, set the divider, h_count and v_count to 0, vga_rgb to 12'h000, hsync and vsync to 1, and frame_start to 0 on that edge.
REQ-030 SHALL treat rst mid-frame identically: the first p_tick after deassertion occurs CLK_DIV clks later and advances to (1,0).
REQ-031 SHALL override a coincident p_tick with rst.

Structure
REQ-032 SHALL place default timing constants and the H_TOTAL/V_TOTAL derivations in shared package vga_pkg, for the renderer and sync controller to use alike.
REQ-033 SHALL implement the divider as sub-module pixel_tick_gen (ports clk, rst, p_tick; parameter CLK_DIV); the counters and output registers stay in vga_sync_ctrl.

Verification
REQ-034 SHALL cover: release rst with CLK_DIV=4 -> p_tick on clks 4, 8, 12...; pixel_x = 1 after the first tick; hsync = vsync = 1 and vga_rgb = 0 during and right after reset.
REQ-035 SHALL cover: run one full line -> hsync low for exactly 96 p_ticks starting on the registered tick following h_count=656; pixel_y increments when pixel_x goes from 799 to 0.
REQ-036 SHALL cover: run one full frame -> vsync low for exactly 2 lines (v 490..491, +1 pixel latency); frame_start pulses once per 420000 p_ticks.
REQ-037 SHALL cover: rgb_in = 12'hF0F constant -> vga_rgb = F0F for visible pixels, 000 at x 640..799 and y 480..524, and colour lags pixel_x by 1 tick.
REQ-038 SHALL cover: assert rst at (x=300, y=200) for 3 clks -> next clk shows x=0, y=0, vga_rgb=0, hsync = vsync = 1, and counting resumes correctly.
REQ-039 SHALL cover: CLK_DIV=1 -> p_tick constantly high, with the line period = 800 clks.
